// File: rtl/mem_stage_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_stage_pkg
// Purpose  : Shared widths, load/store size codes and FSM encoding for the
//            tc_l1 memory-access stage.
// Revision : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    localparam int c_REG_BUS      = 64;
    localparam int c_REG_ADDR_BUS = 5;

    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LW  = 3'b010;
    localparam logic [2:0] c_F3_LD  = 3'b011;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;
    localparam logic [2:0] c_F3_LWU = 3'b110;

    localparam logic [2:0] c_F3_SB  = 3'b000;
    localparam logic [2:0] c_F3_SH  = 3'b001;
    localparam logic [2:0] c_F3_SW  = 3'b010;
    localparam logic [2:0] c_F3_SD  = 3'b011;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Natural alignment: the size code in funct3[1:0] sets how many low
    // address bits must be zero.
    function automatic logic f_aligned(input logic [2:0] funct3, input logic [2:0] off);
        case (funct3[1:0])
            2'b00:   f_aligned = 1'b1;
            2'b01:   f_aligned = (off[0] == 1'b0);
            2'b10:   f_aligned = (off[1:0] == 2'b00);
            default: f_aligned = (off == 3'b000);
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lsu_align.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_lsu_align
// Purpose  : Combinational lane logic: load extract/extend and store
//            shift/byte-strobe generation.
// Revision : 1.0 - initial release
// ============================================================================
module mem_lsu_align
    import mem_stage_pkg::*;
#(
    parameter int XLEN = c_REG_BUS
) (
    input  logic [2:0]      ld_funct3_i,
    input  logic [2:0]      ld_off_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] ld_data_o,
    input  logic [2:0]      st_funct3_i,
    input  logic [2:0]      st_off_i,
    input  logic [XLEN-1:0] st_data_i,
    output logic [XLEN-1:0] st_wdata_o,
    output logic [7:0]      st_wmask_o
);

    logic [XLEN-1:0] w_raw;

    always_comb begin
        w_raw = rdata_i >> {ld_off_i, 3'b000};
        case (ld_funct3_i)
            c_F3_LB:  ld_data_o = {{(XLEN-8){w_raw[7]}},   w_raw[7:0]};
            c_F3_LH:  ld_data_o = {{(XLEN-16){w_raw[15]}}, w_raw[15:0]};
            c_F3_LW:  ld_data_o = {{(XLEN-32){w_raw[31]}}, w_raw[31:0]};
            c_F3_LBU: ld_data_o = {{(XLEN-8){1'b0}},       w_raw[7:0]};
            c_F3_LHU: ld_data_o = {{(XLEN-16){1'b0}},      w_raw[15:0]};
            c_F3_LWU: ld_data_o = {{(XLEN-32){1'b0}},      w_raw[31:0]};
            default:  ld_data_o = w_raw;
        endcase
    end

    always_comb begin
        st_wdata_o = st_data_i << {st_off_i, 3'b000};
        case (st_funct3_i[1:0])
            2'b00:   st_wmask_o = 8'h01 << st_off_i;
            2'b01:   st_wmask_o = 8'h03 << st_off_i;
            2'b10:   st_wmask_o = 8'h0F << st_off_i;
            default: st_wmask_o = 8'hFF;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Memory-access stage: issues loads/stores over a req/ready bus
//            and drives the registered MEM/WB boundary.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN    = c_REG_BUS,
    parameter int RADDR_W = c_REG_ADDR_BUS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_valid_i,
    input  logic [XLEN-1:0]    ex_reg_wdata_i,
    input  logic               ex_reg_we_i,
    input  logic [RADDR_W-1:0] ex_reg_waddr_i,
    input  logic               ex_ld_i,
    input  logic               ex_st_i,
    input  logic [2:0]         ex_funct3_i,
    input  logic [XLEN-1:0]    ex_mem_addr_i,
    input  logic [XLEN-1:0]    ex_st_data_i,
    output logic               stall_o,
    output logic               dmem_req_o,
    output logic               dmem_we_o,
    output logic [XLEN-1:0]    dmem_addr_o,
    output logic [XLEN-1:0]    dmem_wdata_o,
    output logic [7:0]         dmem_wmask_o,
    input  logic               dmem_ready_i,
    input  logic [XLEN-1:0]    dmem_rdata_i,
    output logic [XLEN-1:0]    reg_wdata_o,
    output logic               reg_we_o,
    output logic [RADDR_W-1:0] reg_waddr_o,
    output logic               mem_exc_o
);

    state_e               state_q;
    logic                 ld_q;
    logic [2:0]           funct3_q;
    logic [2:0]           off_q;
    logic [RADDR_W-1:0]   waddr_q;
    logic                 we_q;

    logic                 dmem_req_q;
    logic                 dmem_we_q;
    logic [XLEN-1:0]      dmem_addr_q;
    logic [XLEN-1:0]      dmem_wdata_q;
    logic [7:0]           dmem_wmask_q;
    logic [XLEN-1:0]      reg_wdata_q;
    logic                 reg_we_q;
    logic [RADDR_W-1:0]   reg_waddr_q;
    logic                 mem_exc_q;

    logic                 w_mem_op;
    logic                 w_legal;
    logic                 w_aligned;
    logic                 w_issue;
    logic [XLEN-1:0]      w_ld_data;
    logic [XLEN-1:0]      w_st_wdata;
    logic [7:0]           w_st_wmask;

    assign w_mem_op  = ex_valid_i & (ex_ld_i | ex_st_i);
    assign w_legal   = ex_ld_i ? (ex_funct3_i != 3'b111) : (ex_funct3_i[2] == 1'b0);
    assign w_aligned = f_aligned(ex_funct3_i, ex_mem_addr_i[2:0]);
    assign w_issue   = w_mem_op & w_legal & w_aligned;

    assign stall_o = (state_q == IDLE) ? w_issue : ~dmem_ready_i;

    // Load side works from the latched op; store side from the live execute inputs.
    mem_lsu_align #(.XLEN(XLEN)) u_align (
        .ld_funct3_i (funct3_q),
        .ld_off_i    (off_q),
        .rdata_i     (dmem_rdata_i),
        .ld_data_o   (w_ld_data),
        .st_funct3_i (ex_funct3_i),
        .st_off_i    (ex_mem_addr_i[2:0]),
        .st_data_i   (ex_st_data_i),
        .st_wdata_o  (w_st_wdata),
        .st_wmask_o  (w_st_wmask)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ld_q         <= 1'b0;
            funct3_q     <= '0;
            off_q        <= '0;
            waddr_q      <= '0;
            we_q         <= 1'b0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            dmem_wmask_q <= '0;
            reg_wdata_q  <= '0;
            reg_we_q     <= 1'b0;
            reg_waddr_q  <= '0;
            mem_exc_q    <= 1'b0;
        end else begin
            mem_exc_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (w_mem_op) begin
                        reg_we_q <= 1'b0;
                        if (w_legal && w_aligned) begin
                            state_q      <= BUSY;
                            ld_q         <= ex_ld_i;
                            funct3_q     <= ex_funct3_i;
                            off_q        <= ex_mem_addr_i[2:0];
                            waddr_q      <= ex_reg_waddr_i;
                            we_q         <= ex_reg_we_i;
                            dmem_req_q   <= 1'b1;
                            dmem_we_q    <= ex_st_i;
                            dmem_addr_q  <= {ex_mem_addr_i[XLEN-1:3], 3'b000};
                            dmem_wdata_q <= ex_st_i ? w_st_wdata : '0;
                            dmem_wmask_q <= ex_st_i ? w_st_wmask : 8'h00;
                        end else begin
                            mem_exc_q <= 1'b1;
                        end
                    end else begin
                        reg_wdata_q <= ex_reg_wdata_i;
                        reg_waddr_q <= ex_reg_waddr_i;
                        reg_we_q    <= ex_valid_i & ex_reg_we_i & (ex_reg_waddr_i != '0);
                    end
                end
                BUSY: begin
                    reg_we_q <= 1'b0;
                    if (dmem_ready_i) begin
                        state_q    <= IDLE;
                        dmem_req_q <= 1'b0;
                        if (ld_q) begin
                            reg_wdata_q <= w_ld_data;
                            reg_waddr_q <= waddr_q;
                            reg_we_q    <= we_q & (waddr_q != '0);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dmem_req_o   = dmem_req_q;
    assign dmem_we_o    = dmem_we_q;
    assign dmem_addr_o  = dmem_addr_q;
    assign dmem_wdata_o = dmem_wdata_q;
    assign dmem_wmask_o = dmem_wmask_q;
    assign reg_wdata_o  = reg_wdata_q;
    assign reg_we_o     = reg_we_q;
    assign reg_waddr_o  = reg_waddr_q;
    assign mem_exc_o    = mem_exc_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Scoreboard bench for mem_stage with directed load/store vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_reg_we, ex_ld, ex_st;
    logic [63:0] ex_reg_wdata, ex_mem_addr, ex_st_data;
    logic [4:0]  ex_reg_waddr;
    logic [2:0]  ex_funct3;
    logic        stall_o, dmem_req_o, dmem_we_o, dmem_ready, reg_we_o, mem_exc_o;
    logic [63:0] dmem_addr_o, dmem_wdata_o, dmem_rdata, reg_wdata_o;
    logic [7:0]  dmem_wmask_o;
    logic [4:0]  reg_waddr_o;

    always #5 clk = ~clk;

    mem_stage #(.XLEN(64), .RADDR_W(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid_i     (ex_valid),
        .ex_reg_wdata_i (ex_reg_wdata),
        .ex_reg_we_i    (ex_reg_we),
        .ex_reg_waddr_i (ex_reg_waddr),
        .ex_ld_i        (ex_ld),
        .ex_st_i        (ex_st),
        .ex_funct3_i    (ex_funct3),
        .ex_mem_addr_i  (ex_mem_addr),
        .ex_st_data_i   (ex_st_data),
        .stall_o        (stall_o),
        .dmem_req_o     (dmem_req_o),
        .dmem_we_o      (dmem_we_o),
        .dmem_addr_o    (dmem_addr_o),
        .dmem_wdata_o   (dmem_wdata_o),
        .dmem_wmask_o   (dmem_wmask_o),
        .dmem_ready_i   (dmem_ready),
        .dmem_rdata_i   (dmem_rdata),
        .reg_wdata_o    (reg_wdata_o),
        .reg_we_o       (reg_we_o),
        .reg_waddr_o    (reg_waddr_o),
        .mem_exc_o      (mem_exc_o)
    );

    typedef struct { logic exc; logic [4:0] waddr; logic [63:0] wdata; } wb_t;
    typedef struct { logic we; logic [63:0] addr; logic [63:0] wdata; logic [7:0] wmask; } bus_t;

    wb_t  wb_q[$];
    bus_t bus_q[$];
    int   tests = 0;
    int   fails = 0;
    int   stall_cnt = 0;
    logic prev_req = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // Monitor: pops an expectation whenever the DUT presents a writeback,
    // an exception pulse, or a new bus request.
    always @(negedge clk) begin
        wb_t  e;
        bus_t b;
        if (!rst) begin
            if (stall_o) stall_cnt++;
            if (reg_we_o || mem_exc_o) begin
                if (wb_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL wb_unexpected: we=%b exc=%b waddr=%0d wdata=%h, expected no writeback",
                             reg_we_o, mem_exc_o, reg_waddr_o, reg_wdata_o);
                end else begin
                    e = wb_q.pop_front();
                    chk("wb_we_exc", {62'd0, reg_we_o, mem_exc_o}, {62'd0, !e.exc, e.exc});
                    if (!e.exc) begin
                        chk("wb_waddr", {59'd0, reg_waddr_o}, {59'd0, e.waddr});
                        chk("wb_wdata", reg_wdata_o, e.wdata);
                    end
                end
            end
            if (dmem_req_o && !prev_req) begin
                if (bus_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL bus_unexpected: addr=%h we=%b, expected no request", dmem_addr_o, dmem_we_o);
                end else begin
                    b = bus_q.pop_front();
                    chk("bus_we", {63'd0, dmem_we_o}, {63'd0, b.we});
                    chk("bus_addr", dmem_addr_o, b.addr);
                    if (b.we) begin
                        chk("bus_wdata", dmem_wdata_o, b.wdata);
                        chk("bus_wmask", {56'd0, dmem_wmask_o}, {56'd0, b.wmask});
                    end
                end
            end
        end
        prev_req = dmem_req_o;
    end

    task automatic idle_inputs();
        ex_valid = 0; ex_reg_we = 0; ex_ld = 0; ex_st = 0;
        ex_reg_wdata = '0; ex_mem_addr = '0; ex_st_data = '0;
        ex_reg_waddr = '0; ex_funct3 = '0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_wdata"}, reg_wdata_o, 64'd0);
        chk({tag, "_addr"}, dmem_addr_o, 64'd0);
        chk({tag, "_bus_wdata"}, dmem_wdata_o, 64'd0);
        chk({tag, "_ctrl"}, {42'd0, stall_o, dmem_req_o, dmem_we_o, dmem_wmask_o, reg_we_o, reg_waddr_o, mem_exc_o}, 64'd0);
    endtask

    task automatic pass_through(input logic [4:0] waddr, input logic [63:0] wdata);
        ex_valid = 1; ex_reg_we = 1; ex_reg_waddr = waddr; ex_reg_wdata = wdata;
        stall_cnt = 0;
        @(posedge clk); #1; idle_inputs();
        @(posedge clk); #1;
        chk("alu_stall", 64'(stall_cnt), 64'd0);
    endtask

    // Caller pushes the bus/writeback expectations before calling.
    task automatic mem_op(input logic ld, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] sdata, input logic [4:0] waddr, input logic we,
                          input int delay, input logic [63:0] rdata, input int exp_stall);
        ex_valid = 1; ex_ld = ld; ex_st = !ld; ex_funct3 = f3; ex_mem_addr = addr;
        ex_st_data = sdata; ex_reg_waddr = waddr; ex_reg_we = we; ex_reg_wdata = 64'hBAD;
        stall_cnt = 0;
        @(posedge clk); #1; idle_inputs();
        repeat (delay) begin @(posedge clk); #1; end
        dmem_ready = 1; dmem_rdata = rdata;
        @(posedge clk); #1; dmem_ready = 0; dmem_rdata = '0;
        @(posedge clk); #1;
        chk("op_stall_cycles", 64'(stall_cnt), 64'(exp_stall));
    endtask

    task automatic exc_op(input logic ld, input logic [2:0] f3, input logic [63:0] addr);
        ex_valid = 1; ex_ld = ld; ex_st = !ld; ex_funct3 = f3; ex_mem_addr = addr;
        ex_reg_waddr = 5'd8; ex_reg_we = ld;
        stall_cnt = 0;
        @(posedge clk); #1; idle_inputs();
        repeat (2) begin @(posedge clk); #1; end
        chk("exc_stall", 64'(stall_cnt), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; dmem_ready = 0; dmem_rdata = '0; idle_inputs();
        repeat (3) @(posedge clk);
        #1 rst = 0;
        check_all_zero("reset");

        wb_q.push_back('{0, 5'd5, 64'h1234});
        pass_through(5'd5, 64'h1234);

        bus_q.push_back('{0, 64'h1000, 64'h0, 8'h00});
        wb_q.push_back('{0, 5'd1, 64'hFFFF_FFFF_FFFF_FF80});
        mem_op(1, c_F3_LB, 64'h1003, 64'h0, 5'd1, 1, 3, 64'h0000_0000_8000_0000, 4);

        bus_q.push_back('{0, 64'h2000, 64'h0, 8'h00});
        wb_q.push_back('{0, 5'd7, 64'h0000_0000_DEAD_BEEF});
        mem_op(1, c_F3_LWU, 64'h2004, 64'h0, 5'd7, 1, 1, 64'hDEAD_BEEF_0000_0000, 2);

        bus_q.push_back('{1, 64'h3000, 64'hABCD_0000_0000_0000, 8'hC0});
        mem_op(0, c_F3_SH, 64'h3006, 64'hABCD, 5'd0, 0, 0, 64'h0, 1);

        wb_q.push_back('{1, 5'd0, 64'h0});
        exc_op(1, c_F3_LW, 64'h4002);

        bus_q.push_back('{0, 64'h5000, 64'h0, 8'h00});
        mem_op(1, c_F3_LD, 64'h5000, 64'h0, 5'd0, 1, 0, 64'h123, 1);

        bus_q.push_back('{0, 64'h6000, 64'h0, 8'h00});
        wb_q.push_back('{0, 5'd9, 64'hFFFF_FFFF_FFFF_8001});
        mem_op(1, c_F3_LH, 64'h6002, 64'h0, 5'd9, 1, 2, 64'h0000_0000_8001_0000, 3);

        bus_q.push_back('{1, 64'h7000, 64'h6677_AA00_0000_0000, 8'h20});
        mem_op(0, c_F3_SB, 64'h7005, 64'h1122_3344_5566_77AA, 5'd0, 0, 1, 64'h0, 2);

        bus_q.push_back('{1, 64'h8000, 64'h0123_4567_89AB_CDEF, 8'hFF});
        mem_op(0, c_F3_SD, 64'h8000, 64'h0123_4567_89AB_CDEF, 5'd0, 0, 0, 64'h0, 1);

        bus_q.push_back('{0, 64'h9000, 64'h0, 8'h00});
        wb_q.push_back('{0, 5'd10, 64'h0000_0000_0000_00F0});
        mem_op(1, c_F3_LBU, 64'h9007, 64'h0, 5'd10, 1, 0, 64'hF000_0000_0000_0000, 1);

        bus_q.push_back('{0, 64'hA000, 64'h0, 8'h00});
        wb_q.push_back('{0, 5'd11, 64'hFFFF_FFFF_8765_4321});
        mem_op(1, c_F3_LW, 64'hA004, 64'h0, 5'd11, 1, 1, 64'h8765_4321_0000_0000, 2);

        wb_q.push_back('{1, 5'd0, 64'h0});
        exc_op(0, 3'b100, 64'hB000);
        wb_q.push_back('{1, 5'd0, 64'h0});
        exc_op(1, 3'b111, 64'hB008);

        // Abandon an outstanding load with reset.
        bus_q.push_back('{0, 64'hC000, 64'h0, 8'h00});
        ex_valid = 1; ex_ld = 1; ex_funct3 = c_F3_LW; ex_mem_addr = 64'hC000;
        ex_reg_waddr = 5'd3; ex_reg_we = 1;
        @(posedge clk); #1; idle_inputs();
        @(posedge clk); #1;
        chk("busy_req_held", {63'd0, dmem_req_o}, 64'd1);
        rst = 1;
        @(posedge clk); #1; rst = 0;
        check_all_zero("rst_busy");

        wb_q.push_back('{0, 5'd12, 64'hCAFE});
        pass_through(5'd12, 64'hCAFE);

        chk("wb_queue_empty", 64'(wb_q.size()), 64'd0);
        chk("bus_queue_empty", 64'(bus_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the tc_l1 in-order core. Sits between the execute stage and the writeback stage.
- Issues loads and stores to the data-memory port through a req/ready handshake. Aligns and sign- or zero-extends load data.
- Drives the registered MEM/WB boundary that feeds writeback's reg_wdata/reg_we/reg_waddr inputs.
- Stalls upstream while a memory access is outstanding.

Parameters:
- XLEN, 64, data and address width; must be 64.
- RADDR_W, 5, general-purpose register address width.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid_i  in  1  execute-stage result valid this cycle.
- ex_reg_wdata_i  in  XLEN  ALU result; also the pass-through write data for non-memory ops.
- ex_reg_we_i  in  1  instruction writes a GPR.
- ex_reg_waddr_i  in  RADDR_W  destination GPR.
- ex_ld_i  in  1  instruction is a load.
- ex_st_i  in  1  instruction is a store.
- ex_funct3_i  in  3  load/store size code, RISC-V funct3 encoding.
- ex_mem_addr_i  in  XLEN  effective address.
- ex_st_data_i  in  XLEN  store data (rs2).
- stall_o  out  1  hold execute-stage inputs stable.
- dmem_req_o  out  1  data-bus request.
- dmem_we_o  out  1  1 = store, 0 = load.
- dmem_addr_o  out  XLEN  address with bits [2:0] forced to 0.
- dmem_wdata_o  out  XLEN  lane-shifted store data.
- dmem_wmask_o  out  8  byte-write strobes.
- dmem_ready_i  in  1  one-cycle pulse: access done; dmem_rdata_i valid for loads.
- dmem_rdata_i  in  XLEN  aligned 64-bit read data.
- reg_wdata_o  out  XLEN  to writeback: write data.
- reg_we_o  out  1  to writeback: write enable.
- reg_waddr_o  out  RADDR_W  to writeback: write address.
- mem_exc_o  out  1  one-cycle pulse: misaligned address or illegal funct3.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal latches 0.
- A memory op is ex_valid_i & (ex_ld_i | ex_st_i). ld and st are never both set.
- Legal funct3 for loads: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
- Legal funct3 for stores: 000 to 011.
- Aligned means addr[0] = 0 for halfwords, addr[1:0] = 0 for words, addr[2:0] = 0 for doublewords.
- FSM states: IDLE and BUSY.
- IDLE, no memory op:
  - Next edge: reg_wdata_o <= ex_reg_wdata_i, reg_waddr_o <= ex_reg_waddr_i, reg_we_o <= ex_valid_i & ex_reg_we_i & (waddr != 0).
  - Latency 1. stall_o = 0.
- IDLE, legal and aligned memory op:
  - stall_o = 1 combinationally.
  - Next edge: latch ld, funct3, addr[2:0], waddr and we; drive dmem_req_o = 1 with addr, wdata and wmask registered; reg_we_o <= 0; go to BUSY.
- IDLE, illegal or misaligned memory op:
  - No request is issued; stall_o = 0.
  - Next edge: mem_exc_o <= 1 and reg_we_o <= 0.
- BUSY:
  - dmem_req_o and the bus fields are held stable until dmem_ready_i; the request is never retracted.
  - stall_o = ~dmem_ready_i. Execute-stage inputs are ignored in this state.
  - reg_we_o stays 0 (bubble) while waiting.
- BUSY, dmem_ready_i = 1: on that edge:
  - dmem_req_o <= 0; return to IDLE.
  - Load: reg_wdata_o <= extended data; reg_we_o <= latched_we & (waddr != 0).
  - Store: reg_we_o <= 0.
  - Exception from the previous op: none. mem_exc_o is 0 whenever it is not pulsing.
- dmem_ready_i while IDLE is ignored.
- Load lane extraction:
  - off = addr[2:0]; raw = dmem_rdata_i >> (off*8).
  - Take the low 8, 16, 32 or 64 bits of raw. Sign-extend for LB, LH and LW; zero-extend for LBU, LHU and LWU.
- Store lane placement:
  - dmem_wdata_o = st_data << (off*8).
  - dmem_wmask_o: SB 8'h01<<off, SH 8'h03<<off, SW 8'h0F<<off, SD 8'hFF.
- Single outstanding access. Minimum load/store latency is 2 cycles (issue edge plus the ready edge).
- rst asserted while BUSY: the next edge returns to IDLE and drops dmem_req_o. The bus must tolerate an abandoned request.

Decomposition:
- Shared package or defines: the RegBus and RegAddrBus widths, LB through LWU and SB through SD funct3 constants, and the state encoding (IDLE = 0, BUSY = 1).
- One sub-module: mem_lsu_align. It is purely combinational and holds both the load-extend path and the store-shift/mask path.
- The FSM and the output registers stay in mem_stage.

Test Plan:
- ALU pass-through: valid, we = 1, waddr = 5, wdata = 0x1234, no memory op -> next cycle reg_we_o = 1, waddr = 5, wdata = 0x1234, stall_o = 0.
- LB sign-extend:
  - Stimulus: addr = 0x1003; dmem_ready_i given 3 cycles after the request with rdata = 0x0000_0000_8000_0000.
  - Response: dmem_addr_o = 0x1000; stall_o high for 4 cycles; reg_wdata_o = 0xFFFF_FFFF_FFFF_FF80.
- LWU zero-extend: addr = 0x2004, rdata = 0xDEADBEEF_00000000, ready after 1 cycle -> reg_wdata_o = 0x0000_0000_DEAD_BEEF, reg_we_o = 1.
- SH: addr = 0x3006, st_data = 0xABCD -> dmem_we_o = 1, wmask = 8'hC0, wdata = 0xABCD_0000_0000_0000; reg_we_o stays 0 on completion.
- Misaligned LW at 0x4002 -> no dmem_req_o, mem_exc_o pulses for 1 cycle, reg_we_o = 0, stall_o = 0.
- Load to x0 -> reg_we_o = 0.
- rst while BUSY -> next cycle dmem_req_o = 0, state IDLE, all outputs 0.
